// File: rtl/hilo_muldiv_sequencer_if.sv
// HI/LO sequencer bus: EX-stage op issue plus the write-back HI/LO write port.
// The master side is the pipeline; the slave side is the sequencer.
interface hilo_muldiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             cancel;
  logic             stall;
  logic             busy;
  logic             reg_hi_write_enable;
  logic [WIDTH-1:0] reg_hi_write_data;
  logic             reg_lo_write_enable;
  logic [WIDTH-1:0] reg_lo_write_data;

  modport master (
    output start, op, operand_a, operand_b, cancel,
    input  stall, busy, reg_hi_write_enable, reg_hi_write_data,
           reg_lo_write_enable, reg_lo_write_data
  );

  modport slave (
    input  start, op, operand_a, operand_b, cancel,
    output stall, busy, reg_hi_write_enable, reg_hi_write_data,
           reg_lo_write_enable, reg_lo_write_data
  );
endinterface

// File: rtl/hilo_muldiv_sequencer.sv
// Sequences all HI/LO updates: 1-cycle registered multiply, WIDTH-iteration
// restoring divide, and MTHI/MTLO moves, with a pipeline stall request.
module hilo_muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input logic                    clock,
  input logic                    reset,
  hilo_muldiv_sequencer_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;        // multiplicand, or dividend/quotient shift register
  logic [WIDTH-1:0] b_q, b_d;        // multiplier, or divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             hi_we_q, hi_we_d, lo_we_q, lo_we_d;
  logic             sgn_q, sgn_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

  logic             idle_or_done, op_valid, op_muldiv, accept;
  logic             is_signed_div, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] a_ext, b_ext, product;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] step_rem, step_quo, quo_fix, rem_fix;

  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign op_valid     = (bus.op >= OP_MULT) && (bus.op <= OP_MTLO);
  assign op_muldiv    = (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);
  assign accept       = !reset && bus.start && !bus.cancel && idle_or_done && op_valid;

  assign bus.stall = (accept && op_muldiv) || (state_q == S_MUL) || (state_q == S_DIV);
  assign bus.busy  = (state_q == S_MUL) || (state_q == S_DIV);
  assign bus.reg_hi_write_enable = hi_we_q;
  assign bus.reg_hi_write_data   = hi_q;
  assign bus.reg_lo_write_enable = lo_we_q;
  assign bus.reg_lo_write_data   = lo_q;

  // Signed operands are sign-extended so the low 2*WIDTH bits of the product are exact.
  assign a_ext   = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign b_ext   = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign product = a_ext * b_ext;

  assign is_signed_div = (bus.op == OP_DIV);
  assign a_neg = is_signed_div && bus.operand_a[WIDTH-1];
  assign b_neg = is_signed_div && bus.operand_b[WIDTH-1];
  assign a_mag = a_neg ? (~bus.operand_a + WIDTH'(1)) : bus.operand_a;
  assign b_mag = b_neg ? (~bus.operand_b + WIDTH'(1)) : bus.operand_b;

  // One restoring step: shift in the next dividend bit, keep the difference if it fits.
  assign trial    = {rem_q, a_q[WIDTH-1]} - {1'b0, b_q};
  assign step_rem = trial[WIDTH] ? {rem_q[WIDTH-2:0], a_q[WIDTH-1]} : trial[WIDTH-1:0];
  assign step_quo = {a_q[WIDTH-2:0], ~trial[WIDTH]};
  assign quo_fix  = neg_quo_q ? (~step_quo + WIDTH'(1)) : step_quo;
  assign rem_fix  = neg_rem_q ? (~step_rem + WIDTH'(1)) : step_rem;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    hi_we_d   = 1'b0;
    lo_we_d   = 1'b0;
    sgn_d     = sgn_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          unique case (bus.op)
            OP_MULT, OP_MULTU: begin
              state_d = S_MUL;
              a_d     = bus.operand_a;
              b_d     = bus.operand_b;
              sgn_d   = (bus.op == OP_MULT);
            end
            OP_DIV, OP_DIVU: begin
              if (bus.operand_b == '0) begin
                state_d = S_DONE;
                hi_we_d = 1'b1;
                lo_we_d = 1'b1;
                hi_d    = bus.operand_a;
                lo_d    = '1;
              end else begin
                state_d   = S_DIV;
                a_d       = a_mag;
                b_d       = b_mag;
                rem_d     = '0;
                cnt_d     = '0;
                neg_quo_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
              end
            end
            OP_MTHI: begin
              state_d = S_DONE;
              hi_we_d = 1'b1;
              hi_d    = bus.operand_a;
            end
            default: begin
              state_d = S_DONE;
              lo_we_d = 1'b1;
              lo_d    = bus.operand_a;
            end
          endcase
        end
      end
      S_MUL: begin
        if (bus.cancel) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          hi_we_d = 1'b1;
          lo_we_d = 1'b1;
          hi_d    = product[2*WIDTH-1:WIDTH];
          lo_d    = product[WIDTH-1:0];
        end
      end
      default: begin
        if (bus.cancel) begin
          state_d = S_IDLE;
        end else begin
          a_d   = step_quo;
          rem_d = step_rem;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_DONE;
            hi_we_d = 1'b1;
            lo_we_d = 1'b1;
            hi_d    = rem_fix;
            lo_d    = quo_fix;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      hi_we_q   <= 1'b0;
      lo_we_q   <= 1'b0;
      sgn_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      hi_we_q   <= hi_we_d;
      lo_we_q   <= lo_we_d;
      sgn_q     <= sgn_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end
endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Directed bench for hilo_muldiv_sequencer: vector table for single ops,
// hand sequences for cancel, reset, back-to-back issue.
module tb_hilo_muldiv_sequencer;
  localparam int unsigned WIDTH = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  hilo_muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();

  hilo_muldiv_sequencer #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hwe;
    logic        lwe;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;   // negedges after accept edge until write seen; 0 = no write
    int          stl;   // cycles with stall high, including the accept cycle
  } vec_t;

  vec_t vecs[14];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.op        = 3'd0;
    bus.operand_a = '0;
    bus.operand_b = '0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int   stl;
    int   lat;
    logic hwe, lwe;
    logic [31:0] hi, lo;
    v   = vecs[idx];
    stl = 0;
    lat = 0;
    hwe = 1'b0;
    lwe = 1'b0;
    hi  = '0;
    lo  = '0;
    @(negedge clock);
    issue(v.op, v.a, v.b);
    #1;
    if (bus.stall) stl++;
    @(posedge clock);
    #1 idle_inputs();
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (bus.reg_hi_write_enable || bus.reg_lo_write_enable) begin
        lat = c;
        hwe = bus.reg_hi_write_enable;
        lwe = bus.reg_lo_write_enable;
        hi  = bus.reg_hi_write_data;
        lo  = bus.reg_lo_write_data;
        if (bus.stall) stl++;
        break;
      end
      if (bus.stall) stl++;
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d stall_cycles", idx), 32'(stl), 32'(v.stl));
    chk($sformatf("v%0d hi_we", idx), 32'(hwe), 32'(v.hwe));
    chk($sformatf("v%0d lo_we", idx), 32'(lwe), 32'(v.lwe));
    if (v.hwe) chk($sformatf("v%0d hi_data", idx), hi, v.hi);
    if (v.lwe) chk($sformatf("v%0d lo_data", idx), lo, v.lo);
    if (v.lat != 0) begin
      @(negedge clock);
      chk($sformatf("v%0d we_one_cycle", idx),
          32'({bus.reg_hi_write_enable, bus.reg_lo_write_enable}), 32'd0);
    end
  endtask

  initial begin
    logic seen;
    vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, 2, 2};
    vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        1'b1, 1'b1, 32'h00000001, 32'hFFFFFFFE, 2, 2};
    vecs[2]  = '{3'd4, 32'd100,      32'd7,        1'b1, 1'b1, 32'd2,        32'd14,       33, 33};
    vecs[3]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 33};
    vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0,        32'h80000000, 33, 33};
    vecs[5]  = '{3'd4, 32'h1234,     32'h0,        1'b1, 1'b1, 32'h1234,     32'hFFFFFFFF, 1, 1};
    vecs[6]  = '{3'd6, 32'hCAFE,     32'h0,        1'b0, 1'b1, 32'h0,        32'hCAFE,     1, 0};
    vecs[7]  = '{3'd5, 32'h5,        32'h9,        1'b1, 1'b0, 32'h5,        32'h0,        1, 0};
    vecs[8]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 1'b1, 1'b1, 32'd1,        32'hFFFFFFFD, 33, 33};
    vecs[9]  = '{3'd4, 32'hFFFFFFFF, 32'h10,       1'b1, 1'b1, 32'hF,        32'h0FFFFFFF, 33, 33};
    vecs[10] = '{3'd1, 32'h80000000, 32'h80000000, 1'b1, 1'b1, 32'h40000000, 32'h0,        2, 2};
    vecs[11] = '{3'd3, 32'hFFFF0000, 32'h0,        1'b1, 1'b1, 32'hFFFF0000, 32'hFFFFFFFF, 1, 1};
    vecs[12] = '{3'd0, 32'h11,       32'h22,       1'b0, 1'b0, 32'h0,        32'h0,        0, 0};
    vecs[13] = '{3'd7, 32'h11,       32'h22,       1'b0, 1'b0, 32'h0,        32'h0,        0, 0};

    idle_inputs();
    bus.cancel = 1'b0;
    #12;
    chk("reset stall", 32'(bus.stall), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset enables", 32'({bus.reg_hi_write_enable, bus.reg_lo_write_enable}), 32'd0);
    chk("reset hi_data", bus.reg_hi_write_data, 32'd0);
    chk("reset lo_data", bus.reg_lo_write_data, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(i);

    // Cancel a signed divide at iteration 10: back to IDLE, no write ever.
    @(negedge clock);
    issue(3'd3, 32'd1000, 32'd3);
    @(posedge clock);
    #1 idle_inputs();
    repeat (9) @(posedge clock);
    #1 bus.cancel = 1'b1;
    @(posedge clock);
    #1 bus.cancel = 1'b0;
    chk("cancel busy", 32'(bus.busy), 32'd0);
    chk("cancel stall", 32'(bus.stall), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      seen = seen | bus.reg_hi_write_enable | bus.reg_lo_write_enable;
    end
    chk("cancel no_write", 32'(seen), 32'd0);

    // Reset at iteration 5: outputs clear without waiting for a clock edge.
    @(negedge clock);
    issue(3'd4, 32'd1000, 32'd3);
    @(posedge clock);
    #1 idle_inputs();
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midreset stall", 32'(bus.stall), 32'd0);
    chk("midreset busy", 32'(bus.busy), 32'd0);
    chk("midreset enables", 32'({bus.reg_hi_write_enable, bus.reg_lo_write_enable}), 32'd0);
    chk("midreset hi_data", bus.reg_hi_write_data, 32'd0);
    chk("midreset lo_data", bus.reg_lo_write_data, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Back-to-back: MULTU issued during MTHI's DONE cycle.
    @(negedge clock);
    issue(3'd5, 32'h5, 32'h0);
    @(posedge clock);
    #1 issue(3'd2, 32'd3, 32'd4);
    @(negedge clock);
    chk("b2b mthi hi_we", 32'(bus.reg_hi_write_enable), 32'd1);
    chk("b2b mthi lo_we", 32'(bus.reg_lo_write_enable), 32'd0);
    chk("b2b mthi hi_data", bus.reg_hi_write_data, 32'h5);
    chk("b2b accept stall", 32'(bus.stall), 32'd1);
    @(posedge clock);
    #1 idle_inputs();
    @(negedge clock);
    chk("b2b mul stall", 32'(bus.stall), 32'd1);
    chk("b2b mul no_we", 32'({bus.reg_hi_write_enable, bus.reg_lo_write_enable}), 32'd0);
    @(negedge clock);
    chk("b2b mul enables", 32'({bus.reg_hi_write_enable, bus.reg_lo_write_enable}), 32'd3);
    chk("b2b mul hi_data", bus.reg_hi_write_data, 32'd0);
    chk("b2b mul lo_data", bus.reg_lo_write_data, 32'd12);

    // start together with cancel is ignored.
    @(negedge clock);
    issue(3'd1, 32'd6, 32'd7);
    bus.cancel = 1'b1;
    #1;
    chk("cancel_start stall", 32'(bus.stall), 32'd0);
    @(posedge clock);
    #1 begin
      idle_inputs();
      bus.cancel = 1'b0;
    end
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      seen = seen | bus.busy | bus.reg_hi_write_enable | bus.reg_lo_write_enable;
    end
    chk("cancel_start ignored", 32'(seen), 32'd0);

    // cancel during DONE does not suppress the write.
    @(negedge clock);
    issue(3'd6, 32'hBEEF, 32'h0);
    @(posedge clock);
    #1 begin
      idle_inputs();
      bus.cancel = 1'b1;
    end
    @(negedge clock);
    chk("done_cancel lo_we", 32'(bus.reg_lo_write_enable), 32'd1);
    chk("done_cancel lo_data", bus.reg_lo_write_data, 32'hBEEF);
    bus.cancel = 1'b0;

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
